hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit for the 5-stage pipelined core: tracks in-flight register writes in an internal E/M/W scoreboard and drives fetch/decode stall, decode/execute flush and per-operand forwarding selects. It sits beside the pipeline registers and consumes only decode-stage register addresses and control bits, so the datapath no longer needs external match comparators. Unlike the fixed two-operand unit, it supports N source operands (including the shift-register operand), condition-failed squashing and optional stall/flush statistics.

## Interface
- NREAD, 3: number of decode source operands (Rn, Rm, Rs)
- AW, 4: register address width
- PC_IDX, 15: register index of the PC; never forwarded
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- issue_valid_d  in  1  decode stage holds a real instruction
- ra_d  in  NREAD×AW  decode source addresses
- ruse_d  in  NREAD  source actually read
- wa_d  in  AW  decode destination address
- we_d, load_d, pcwr_d  in  1 each  writes reg / is load / writes PC
- cond_ok_e  in  1  instruction in E passed its condition check
- branch_taken_e  in  1  branch resolved taken in E
- stall_f, stall_d, flush_d, flush_e  out  1 each  pipeline controls
- fwd_e  out  NREAD×2  per-operand select: 00 regfile, 01 ResultW, 10 ALUOutM
- stall_cnt, flush_cnt  out  32 each  statistics (macro only)

## Operation
- Scoreboard: three entries E, M, W, each {valid, wa, we, load, pcwr}, plus E-stage source regs {ra_e, ruse_e}.
- Per cycle: E ← decode entry (valid = issue_valid_d) unless flush_e, then E ← bubble (valid=0); ra_e/ruse_e captured likewise. M ← E with we/pcwr cleared if !cond_ok_e. W ← M.
- Match rule: entry matches source k iff entry.valid & entry.we & wa==ra & ruse & ra!=PC_IDX.
- fwd_e[k]: 10 if M matches ra_e[k]; else 01 if W matches; else 00. M has priority.
- ldstall: any decode source matches E entry with load=1, qualified by issue_valid_d.
- pcpend: pcwr set on valid decode instr, or in E or M entry.
- branch_taken_e overrides: ldstall_q = ldstall & !branch_taken_e.
- stall_f = ldstall_q | pcpend; stall_d = ldstall_q.
- flush_d = pcpend | branch_taken_e | (W.valid & W.pcwr).
- flush_e = ldstall_q | branch_taken_e.
- Squashed E instr (cond fail) still advances as valid but never matches downstream.

## Timing
- All outputs combinational from scoreboard state and decode inputs; no added latency.
- Load-use: exactly one stall cycle; next cycle E holds bubble, load in M, consumer forwards from W (01)... M is the load → fwd uses W once load reaches W, i.e. one stall cycle then 01.
- PC write: stall_f held 3 cycles (D, E, M), flush_d 4 cycles (through W).
- Reset (reset=0, any time, mid-stall included): all entries invalid immediately; outputs stall/flush 0, fwd_e 00, counters 0.
- Simultaneous branch_taken_e and ldstall: flush both D and E, no stall.

## Configuration
- HAZARD_STATS_EN defined: stall_cnt increments each cycle stall_d=1, flush_cnt each cycle flush_e=1; both saturate at 32'hFFFF_FFFF; cleared by reset.
- Undefined: counters and their logic absent; stall_cnt/flush_cnt tied to 0.

## Structure
- hazard_pkg: sb_entry_t struct, FWD_RF/FWD_W/FWD_M constants (2'b00/01/10).
- Sub-module hazard_sb_stage: one scoreboard entry register with async active-low reset, load, bubble and condition-squash inputs; instantiated three times.

## Test plan
- Reset mid-operation with valid E/M/W entries -> all outputs 0 same cycle; first post-reset issue sees fwd 00.
- ADD r1 then ADD r2,r1 -> next cycle fwd_e[0]=10; with one NOP between -> 01; same reg written in M and W -> 10.
- LDR r3 then ADD r4,r3 -> stall_f=stall_d=flush_e=1 one cycle, then fwd 01, no further stall.
- LDR r3 then ADD using r3 with branch_taken_e=1 -> flush_d=flush_e=1, stall_f=stall_d=0.
- MOV pc,r0 issued -> stall_f=1 for 3 cycles, flush_d=1 for 4; ADD r15 source never forwarded.
- Cond-failed ADD r5 in E then ADD r6,r5 -> fwd 00; with HAZARD_STATS_EN, 3 load-use stalls -> stall_cnt=3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: entry layout,
// forwarding select encodings and the source/entry match helper.
package hazard_pkg;

    localparam int SB_AW_MAX = 8;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [SB_AW_MAX-1:0] wa;
        logic                 we;
        logic                 load;
        logic                 pcwr;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, wa: {SB_AW_MAX{1'b0}},
                                        we: 1'b0, load: 1'b0, pcwr: 1'b0};

    // The PC is excluded because its value comes from the fetch path, not the ALU.
    function automatic logic entry_match(input logic valid, input logic we,
                                         input logic [SB_AW_MAX-1:0] wa,
                                         input logic [SB_AW_MAX-1:0] ra,
                                         input logic rused,
                                         input logic [SB_AW_MAX-1:0] pc_idx);
        return valid & we & (wa == ra) & rused & (ra != pc_idx);
    endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// One scoreboard entry register: loads the upstream entry, inserts a bubble
// on request, and drops write/PC-write intent when the condition failed.
module hazard_sb_stage
    import hazard_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      load_en,
    input  logic      bubble,
    input  logic      squash,
    input  sb_entry_t d,
    output sb_entry_t q
);

    sb_entry_t nxt_s;

    // Next-entry selection: bubble wins over load; squash keeps the entry valid.
    always_comb begin
        nxt_s = q;
        if (bubble) begin
            nxt_s = SB_BUBBLE;
        end else if (load_en) begin
            nxt_s      = d;
            nxt_s.we   = d.we & ~squash;
            nxt_s.pcwr = d.pcwr & ~squash;
        end else begin
            nxt_s = q;
        end
    end

    // Entry register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SB_BUBBLE;
        end else begin
            q <= nxt_s;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit with internal E/M/W write scoreboard: stall, flush and forwarding.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREAD  = 3,
    parameter int AW     = 4,
    parameter int PC_IDX = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid_d,
    input  logic [NREAD-1:0][AW-1:0]   ra_d,
    input  logic [NREAD-1:0]           ruse_d,
    input  logic [AW-1:0]              wa_d,
    input  logic                       we_d,
    input  logic                       load_d,
    input  logic                       pcwr_d,
    input  logic                       cond_ok_e,
    input  logic                       branch_taken_e,
    output logic                       stall_f,
    output logic                       stall_d,
    output logic                       flush_d,
    output logic                       flush_e,
    output logic [NREAD-1:0][1:0]      fwd_e,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                flush_cnt
);

    localparam logic [SB_AW_MAX-1:0] PC_EXT = SB_AW_MAX'(PC_IDX);

    function automatic logic [SB_AW_MAX-1:0] ext_addr(input logic [AW-1:0] a);
        logic [SB_AW_MAX-1:0] r;
        r        = {SB_AW_MAX{1'b0}};
        r[AW-1:0] = a;
        return r;
    endfunction

    sb_entry_t                dec_s;
    sb_entry_t                e_r;
    sb_entry_t                m_r;
    sb_entry_t                w_r;
    logic [NREAD-1:0][AW-1:0] ra_e_r;
    logic [NREAD-1:0]         ruse_e_r;
    logic [NREAD-1:0][1:0]    fwd_s;
    logic                     ldstall_s;
    logic                     ldstall_q_s;
    logic                     pcpend_s;
    logic                     flush_e_s;
    logic                     unused_load_s;

    assign unused_load_s = m_r.load ^ w_r.load;

    // Decode-stage entry presented to the E register.
    always_comb begin
        dec_s       = SB_BUBBLE;
        dec_s.valid = issue_valid_d;
        dec_s.wa    = ext_addr(wa_d);
        dec_s.we    = we_d;
        dec_s.load  = load_d;
        dec_s.pcwr  = pcwr_d;
    end

    hazard_sb_stage u_stage_e (
        .clk     (clk),
        .reset   (reset),
        .load_en (1'b1),
        .bubble  (flush_e_s),
        .squash  (1'b0),
        .d       (dec_s),
        .q       (e_r)
    );

    hazard_sb_stage u_stage_m (
        .clk     (clk),
        .reset   (reset),
        .load_en (1'b1),
        .bubble  (1'b0),
        .squash  (~cond_ok_e),
        .d       (e_r),
        .q       (m_r)
    );

    hazard_sb_stage u_stage_w (
        .clk     (clk),
        .reset   (reset),
        .load_en (1'b1),
        .bubble  (1'b0),
        .squash  (1'b0),
        .d       (m_r),
        .q       (w_r)
    );

    // E-stage source registers; a flushed slot reads nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra_e_r   <= {(NREAD*AW){1'b0}};
            ruse_e_r <= {NREAD{1'b0}};
        end else if (flush_e_s) begin
            ra_e_r   <= {(NREAD*AW){1'b0}};
            ruse_e_r <= {NREAD{1'b0}};
        end else begin
            ra_e_r   <= ra_d;
            ruse_e_r <= ruse_d;
        end
    end

    // Load-use and PC-write hazard detection.
    always_comb begin
        ldstall_s = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            ldstall_s = ldstall_s | (issue_valid_d & e_r.load &
                        entry_match(e_r.valid, e_r.we, e_r.wa, ext_addr(ra_d[k]),
                                    ruse_d[k], PC_EXT));
        end
        ldstall_q_s = ldstall_s & ~branch_taken_e;
        pcpend_s    = (issue_valid_d & pcwr_d) | (e_r.valid & e_r.pcwr) |
                      (m_r.valid & m_r.pcwr);
        flush_e_s   = ldstall_q_s | branch_taken_e;
    end

    // Per-operand forwarding select; the younger M result has priority.
    always_comb begin
        fwd_s = {NREAD{FWD_RF}};
        for (int k = 0; k < NREAD; k++) begin
            if (entry_match(m_r.valid, m_r.we, m_r.wa, ext_addr(ra_e_r[k]),
                            ruse_e_r[k], PC_EXT)) begin
                fwd_s[k] = FWD_M;
            end else if (entry_match(w_r.valid, w_r.we, w_r.wa, ext_addr(ra_e_r[k]),
                                     ruse_e_r[k], PC_EXT)) begin
                fwd_s[k] = FWD_W;
            end else begin
                fwd_s[k] = FWD_RF;
            end
        end
    end

    // Output drive; reset forces every control quiet in the same cycle.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        fwd_e   = {NREAD{FWD_RF}};
        if (reset) begin
            stall_f = ldstall_q_s | pcpend_s;
            stall_d = ldstall_q_s;
            flush_d = pcpend_s | branch_taken_e | (w_r.valid & w_r.pcwr);
            flush_e = flush_e_s;
            fwd_e   = fwd_s;
        end else begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            flush_d = 1'b0;
            flush_e = 1'b0;
            fwd_e   = {NREAD{FWD_RF}};
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating stall/flush event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_d && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_e && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against an
// instruction-level pipeline model held as a queue of in-flight instructions.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

`ifdef HAZARD_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid_d;
    logic [2:0][3:0]  ra_d;
    logic [2:0]       ruse_d;
    logic [3:0]       wa_d;
    logic             we_d, load_d, pcwr_d, cond_ok_e, branch_taken_e;
    logic             stall_f, stall_d, flush_d, flush_e;
    logic [2:0][1:0]  fwd_e;
    logic [31:0]      stall_cnt, flush_cnt;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREAD(3), .AW(4), .PC_IDX(15)) dut (
        .clk(clk), .reset(reset), .issue_valid_d(issue_valid_d), .ra_d(ra_d),
        .ruse_d(ruse_d), .wa_d(wa_d), .we_d(we_d), .load_d(load_d), .pcwr_d(pcwr_d),
        .cond_ok_e(cond_ok_e), .branch_taken_e(branch_taken_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_e(fwd_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // An instruction as seen by the model; killed = failed its condition in E.
    typedef struct {
        bit            valid;
        bit [3:0]      wa;
        bit            we, ld, pc, killed;
        bit [2:0][3:0] ra;
        bit [2:0]      ruse;
    } ins_t;

    ins_t pipe[$];            // [0] in execute, [1] in memory, [2] in writeback
    bit e_sf, e_sd, e_fd, e_fe;
    bit [2:0][1:0] e_fwd;
    int unsigned m_sc = 0, m_fc = 0;
    int sf_seen, fd_seen;

    function automatic ins_t bubble_ins();
        ins_t b;
        b.valid = 1'b0; b.wa = 4'd0; b.we = 1'b0; b.ld = 1'b0; b.pc = 1'b0;
        b.killed = 1'b0; b.ra = 12'd0; b.ruse = 3'b000;
        return b;
    endfunction

    function automatic bit writes(ins_t x, bit [3:0] r);
        return x.valid && x.we && !x.killed && (x.wa == r) && (r != 4'd15);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit ld, pcp;
        ld = 1'b0;
        e_fwd = 6'd0;
        if (!reset) begin
            e_sf = 1'b0; e_sd = 1'b0; e_fd = 1'b0; e_fe = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (issue_valid_d && ruse_d[k] && pipe[0].ld && writes(pipe[0], ra_d[k]))
                    ld = 1'b1;
                if (pipe[0].ruse[k] && writes(pipe[1], pipe[0].ra[k]))
                    e_fwd[k] = FWD_M;
                else if (pipe[0].ruse[k] && writes(pipe[2], pipe[0].ra[k]))
                    e_fwd[k] = FWD_W;
            end
            pcp  = (issue_valid_d && pcwr_d) || (pipe[0].valid && pipe[0].pc) ||
                   (pipe[1].valid && pipe[1].pc && !pipe[1].killed);
            e_sd = ld && !branch_taken_e;
            e_sf = e_sd || pcp;
            e_fd = pcp || branch_taken_e || (pipe[2].valid && pipe[2].pc && !pipe[2].killed);
            e_fe = e_sd || branch_taken_e;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_eval();
        check("stall_f", 32'(stall_f), 32'(e_sf));
        check("stall_d", 32'(stall_d), 32'(e_sd));
        check("flush_d", 32'(flush_d), 32'(e_fd));
        check("flush_e", 32'(flush_e), 32'(e_fe));
        check("fwd_e", 32'(fwd_e), 32'(e_fwd));
        check("stall_cnt", stall_cnt, STATS_ON ? m_sc : 32'd0);
        check("flush_cnt", flush_cnt, STATS_ON ? m_fc : 32'd0);
    endtask

    task automatic adv();
        ins_t n;
        if (!reset) begin
            pipe.delete();
            repeat (3) pipe.push_back(bubble_ins());
            m_sc = 0; m_fc = 0;
        end else begin
            if (e_sd) m_sc++;
            if (e_fe) m_fc++;
            if (!cond_ok_e) pipe[0].killed = 1'b1;
            if (e_fe) begin
                n = bubble_ins();
            end else begin
                n.valid = issue_valid_d; n.wa = wa_d; n.we = we_d; n.ld = load_d;
                n.pc = pcwr_d; n.killed = 1'b0; n.ra = ra_d; n.ruse = ruse_d;
            end
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        at_neg();
        adv();
    endtask

    task automatic drive(bit v, bit [3:0] wa, bit we, bit ld, bit pc,
                         bit [3:0] r0, bit [3:0] r1, bit [3:0] r2, bit [2:0] u);
        issue_valid_d = v; wa_d = wa; we_d = we; load_d = ld; pcwr_d = pc;
        ra_d = {r2, r1, r0}; ruse_d = u;
    endtask

    task automatic nop();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
    endtask

    task automatic load_use();
        drive(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b001);
        step();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 3'b001);
        step();
        step();
        nop();
        step();
    endtask

    function automatic bit [3:0] rreg();
        int x;
        x = $urandom_range(0, 15);
        return (x == 15) ? 4'd15 : 4'(x % 6);
    endfunction

    task automatic rand_drive();
        bit v, pcw, we, ld;
        bit [3:0] wa;
        v   = ($urandom_range(0, 3) != 0);
        pcw = v && ($urandom_range(0, 19) == 0);
        wa  = pcw ? 4'd15 : rreg();
        we  = pcw ? 1'b1 : 1'($urandom_range(0, 1));
        ld  = we && !pcw && ($urandom_range(0, 3) == 0);
        drive(v, wa, we, ld, pcw, rreg(), rreg(), rreg(),
              v ? 3'($urandom_range(0, 7)) : 3'b000);
        cond_ok_e      = ($urandom_range(0, 4) != 0);
        branch_taken_e = ($urandom_range(0, 11) == 0);
        reset          = ($urandom_range(0, 199) != 0);
    endtask

    initial begin
        repeat (3) pipe.push_back(bubble_ins());
        reset = 1'b0; cond_ok_e = 1'b1; branch_taken_e = 1'b0;
        nop();
        @(posedge clk); #1;
        at_neg();
        check("rst_stall_f", 32'(stall_f), 32'd0);
        check("rst_fwd", 32'(fwd_e), 32'd0);
        adv();
        reset = 1'b1;

        // Back-to-back dependency forwards from M.
        drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 4'd0, 3'b011); step();
        drive(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 3'b001); step();
        nop(); at_neg(); check("fwd_m", 32'(fwd_e[0]), 32'(FWD_M)); adv();

        // One instruction gap forwards from W.
        drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 4'd0, 3'b011); step();
        nop(); step();
        drive(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 3'b001); step();
        nop(); at_neg(); check("fwd_w", 32'(fwd_e[0]), 32'(FWD_W)); adv();

        // Same register in M and W: M wins.
        drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 4'd0, 3'b011); step();
        drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 4'd0, 3'b011); step();
        drive(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 3'b001); step();
        nop(); at_neg(); check("fwd_mw", 32'(fwd_e[0]), 32'(FWD_M)); adv();

        // Load-use: single stall, then forward from W.
        drive(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b001); step();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 3'b001);
        at_neg();
        check("lu_stall_f", 32'(stall_f), 32'd1);
        check("lu_stall_d", 32'(stall_d), 32'd1);
        check("lu_flush_e", 32'(flush_e), 32'd1);
        adv();
        at_neg(); check("lu_nostall", 32'(stall_d), 32'd0); adv();
        nop(); at_neg(); check("lu_fwd_w", 32'(fwd_e[0]), 32'(FWD_W)); adv();

        // Load-use coinciding with a taken branch: flush both, no stall.
        drive(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b001); step();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 3'b001);
        branch_taken_e = 1'b1;
        at_neg();
        check("br_flush_d", 32'(flush_d), 32'd1);
        check("br_flush_e", 32'(flush_e), 32'd1);
        check("br_stall_f", 32'(stall_f), 32'd0);
        check("br_stall_d", 32'(stall_d), 32'd0);
        adv();
        branch_taken_e = 1'b0;
        nop(); step(); step(); step();

        // PC write: stall_f over D/E/M, flush_d through W.
        sf_seen = 0; fd_seen = 0;
        drive(1'b1, 4'd15, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 3'b001);
        for (int i = 0; i < 6; i++) begin
            at_neg();
            sf_seen += int'(stall_f);
            fd_seen += int'(flush_d);
            adv();
            nop();
        end
        check("pc_stall3", 32'(sf_seen), 32'd3);
        check("pc_flush4", 32'(fd_seen), 32'd4);

        // r15 is never forwarded.
        drive(1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b001); step();
        drive(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 4'd15, 4'd0, 4'd0, 3'b001); step();
        nop(); at_neg(); check("pc_nofwd", 32'(fwd_e[0]), 32'(FWD_RF)); adv();

        // Condition-failed producer is not forwarded.
        drive(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b001); step();
        drive(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 3'b001);
        cond_ok_e = 1'b0; step(); cond_ok_e = 1'b1;
        nop(); at_neg(); check("cond_fwd", 32'(fwd_e[0]), 32'(FWD_RF)); adv();

        // Reset in the middle of a load-use stall.
        drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b001); step();
        drive(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b001); step();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 3'b001);
        reset = 1'b0;
        at_neg();
        check("mid_rst_stall_f", 32'(stall_f), 32'd0);
        check("mid_rst_flush_d", 32'(flush_d), 32'd0);
        check("mid_rst_flush_e", 32'(flush_e), 32'd0);
        check("mid_rst_cnt", stall_cnt, 32'd0);
        adv();
        reset = 1'b1;
        drive(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 3'b001); step();
        nop(); at_neg(); check("post_rst_fwd", 32'(fwd_e[0]), 32'(FWD_RF)); adv();

        // Three load-use stalls from a clean counter.
        repeat (3) load_use();
        at_neg();
        check("stats_3", stall_cnt, STATS_ON ? 32'd3 : 32'd0);
        adv();

        // Randomized traffic checked every cycle against the model.
        for (int i = 0; i < 2000; i++) begin
            rand_drive();
            step();
        end
        reset = 1'b1;
        nop();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
